cache_bus_arbiter: RTL and testbench
====================================

CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 64, word width.
- OFFSET_LENGTH, 4, line holds 2**OFFSET_LENGTH words; LINE_W = DATA_WIDTH*2**OFFSET_LENGTH.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ic_command_valid  in  1  icache line-fill request.
- ic_command_addr  in  ADDR_WIDTH  icache line address.
- ic_bus_valid  out  1  one-cycle fill-complete pulse to icache.
- ic_invalidate  out  1  one-cycle icache invalidate pulse.
- ic_invalidate_addr  out  ADDR_WIDTH  invalidate line address.
- dc_command_valid  in  1  dcache request.
- dc_command_store  in  1  1 = writeback, 0 = fill.
- dc_command_addr  in  ADDR_WIDTH  dcache line address.
- dc_data_to_bus  in  LINE_W  writeback line.
- dc_bus_valid  out  1  one-cycle fill-complete pulse to dcache.
- dc_bus_ready  out  1  one-cycle writeback-complete pulse to dcache.
- bus_data  out  LINE_W  fill line, shared by both caches.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_store  out  1  1 = write.
- mem_req_addr  out  ADDR_WIDTH  request address, offset bits zero.
- mem_req_data  out  LINE_W  write line.
- mem_resp_valid  in  1  read data valid.
- mem_resp_ready  out  1  arbiter accepts read data.
- mem_resp_data  in  LINE_W  read line.

Function
REQ-003 FSM states: IDLE, ISSUE, WAIT_RESP, RESPOND; exactly one transaction in flight.
REQ-004 IDLE: if any command_valid, grant one requester, latch addr (offset bits forced 0), store flag, write data -> ISSUE; else stay.
REQ-005 Both valid in IDLE: grant the requester pointed to by the 1-bit round-robin pointer; pointer flips to the other requester on every entry to RESPOND.
REQ-006 icache requests are always reads.
REQ-007 ISSUE: mem_req_valid=1 with latched fields held stable until mem_req_ready; on handshake, store -> RESPOND, read -> WAIT_RESP.
REQ-008 WAIT_RESP: mem_resp_ready=1; on mem_resp_valid latch mem_resp_data into bus_data -> RESPOND; mem_resp_valid outside WAIT_RESP is ignored.
REQ-009 RESPOND (one cycle): pulse the granted requester's ic_bus_valid, dc_bus_valid or dc_bus_ready; bus_data holds the line; -> IDLE.
REQ-010 Minimum latency: read request sampled in cycle 0 -> mem_req_valid in cycle 1 -> response pulse in cycle 3 when mem is zero-wait; store pulse in cycle 2.
REQ-011 Requester dropping command_valid mid-transaction does not abort it; the pulse is still issued.
REQ-012 Request held valid in the RESPOND cycle is re-evaluated in IDLE as a new request.
REQ-013 All outputs registered except mem_resp_ready, which is decoded from state.

Reset
REQ-014 reset low: state=IDLE, pointer=dcache, every output 0, bus_data 0, in-flight transaction dropped without response.
REQ-015 Release of reset takes effect at the next clk edge; no request is sampled during reset.

Configuration
REQ-016 ARB_ICACHE_SNOOP_EN defined: on a dcache store memory handshake, ic_invalidate=1 for exactly the next cycle with ic_invalidate_addr = store line address.
REQ-017 ARB_ICACHE_SNOOP_EN undefined: ic_invalidate and ic_invalidate_addr tied 0, no snoop logic present.

Structure
REQ-018 Package cache_bus_pkg holds the arb_state_e enum, the requester-id enum (REQ_IC, REQ_DC) and the LINE_W width function.
REQ-019 Single module, no sub-module; round-robin pointer and FSM are inline.

Verification
REQ-020 Lone icache read addr 0x1234: mem_req_addr=0x1230, mem_resp_data=A -> ic_bus_valid pulse in cycle 3, bus_data=A.
REQ-021 Both valid after reset: dcache served first, icache next; pointer alternates over 4 back-to-back pairs.
REQ-022 dcache store, mem_req_ready low for 5 cycles: request fields stable, dc_bus_ready pulses once after handshake.
REQ-023 reset low during WAIT_RESP: all outputs 0, no pulse, next request served normally.
REQ-024 With ARB_ICACHE_SNOOP_EN, dcache store to 0x4000: ic_invalidate one cycle with addr 0x4000; without the macro, it stays 0.

Source files
------------

// File: rtl/cache_bus_pkg.sv
`default_nettype none
// ============================================================================
// cache_bus_pkg : arbiter states, requester ids and line-width helper
// Rev 1.0 : initial release
// ============================================================================
package cache_bus_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        RESPOND   = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } req_id_e;

    function automatic int line_w(input int data_width, input int offset_length);
        return data_width * (2 ** offset_length);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_bus_arbiter.sv
`default_nettype none
// ============================================================================
// cache_bus_arbiter : round-robin arbiter putting icache/dcache line requests
//                     onto a single-outstanding memory port.
// Optional macro ARB_ICACHE_SNOOP_EN : invalidate icache line on dcache store.
// Rev 1.0 : initial release
// ============================================================================
module cache_bus_arbiter
    import cache_bus_pkg::*;
#(
    parameter int ADDR_WIDTH    = 64,
    parameter int DATA_WIDTH    = 64,
    parameter int OFFSET_LENGTH = 4,
    localparam int LINE_W       = line_w(DATA_WIDTH, OFFSET_LENGTH)
)(
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  ic_command_valid,
    input  logic [ADDR_WIDTH-1:0] ic_command_addr,
    output logic                  ic_bus_valid,
    output logic                  ic_invalidate,
    output logic [ADDR_WIDTH-1:0] ic_invalidate_addr,

    input  logic                  dc_command_valid,
    input  logic                  dc_command_store,
    input  logic [ADDR_WIDTH-1:0] dc_command_addr,
    input  logic [LINE_W-1:0]     dc_data_to_bus,
    output logic                  dc_bus_valid,
    output logic                  dc_bus_ready,

    output logic [LINE_W-1:0]     bus_data,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_store,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [LINE_W-1:0]     mem_req_data,
    input  logic                  mem_resp_valid,
    output logic                  mem_resp_ready,
    input  logic [LINE_W-1:0]     mem_resp_data
);

    localparam logic [ADDR_WIDTH-1:0] c_offset_mask = ADDR_WIDTH'((1 << OFFSET_LENGTH) - 1);

    arb_state_e            r_state;
    req_id_e               r_rr_ptr;
    req_id_e               r_grant;

    req_id_e               w_grant;
    logic                  w_store;
    logic [ADDR_WIDTH-1:0] w_line_addr;
    logic                  w_enter_respond;
    logic                  w_store_handshake;

    // Contention is resolved by the pointer; a lone requester wins outright.
    always_comb begin
        w_grant = r_rr_ptr;
        if (ic_command_valid && !dc_command_valid) begin
            w_grant = REQ_IC;
        end else if (dc_command_valid && !ic_command_valid) begin
            w_grant = REQ_DC;
        end
    end

    assign w_store     = (w_grant == REQ_DC) && dc_command_store;
    assign w_line_addr = ((w_grant == REQ_IC) ? ic_command_addr : dc_command_addr) & ~c_offset_mask;

    assign w_store_handshake = (r_state == ISSUE) && mem_req_ready && mem_req_store;
    assign w_enter_respond   = w_store_handshake || ((r_state == WAIT_RESP) && mem_resp_valid);

    assign mem_resp_ready = (r_state == WAIT_RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_rr_ptr      <= REQ_DC;
            r_grant       <= REQ_DC;
            ic_bus_valid  <= 1'b0;
            dc_bus_valid  <= 1'b0;
            dc_bus_ready  <= 1'b0;
            bus_data      <= '0;
            mem_req_valid <= 1'b0;
            mem_req_store <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
        end else begin
            ic_bus_valid <= 1'b0;
            dc_bus_valid <= 1'b0;
            dc_bus_ready <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (ic_command_valid || dc_command_valid) begin
                        r_grant       <= w_grant;
                        mem_req_valid <= 1'b1;
                        mem_req_store <= w_store;
                        mem_req_addr  <= w_line_addr;
                        mem_req_data  <= w_store ? dc_data_to_bus : '0;
                        r_state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        r_state       <= mem_req_store ? RESPOND : WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (mem_resp_valid) begin
                        bus_data <= mem_resp_data;
                        r_state  <= RESPOND;
                    end
                end
                RESPOND: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Completion pulses are raised on the edge that enters RESPOND.
            if (w_enter_respond) begin
                ic_bus_valid <= (r_grant == REQ_IC);
                dc_bus_valid <= (r_grant == REQ_DC) && !mem_req_store;
                dc_bus_ready <= (r_grant == REQ_DC) && mem_req_store;
                r_rr_ptr     <= req_id_e'(~r_rr_ptr);
            end
        end
    end

`ifdef ARB_ICACHE_SNOOP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ic_invalidate      <= 1'b0;
            ic_invalidate_addr <= '0;
        end else begin
            ic_invalidate <= w_store_handshake && (r_grant == REQ_DC);
            if (w_store_handshake && (r_grant == REQ_DC)) begin
                ic_invalidate_addr <= mem_req_addr;
            end
        end
    end
`else
    assign ic_invalidate      = 1'b0;
    assign ic_invalidate_addr = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_cache_bus_arbiter : scoreboard bench with a small memory model
// Rev 1.0 : initial release
// ============================================================================
module tb_cache_bus_arbiter;

    localparam int AW     = 64;
    localparam int DW     = 64;
    localparam int OL     = 4;
    localparam int LINE_W = DW * (2 ** OL);

    localparam int K_IC_FILL = 0;
    localparam int K_DC_FILL = 1;
    localparam int K_DC_WB   = 2;

    typedef struct {
        logic              store;
        logic [AW-1:0]     addr;
        logic [LINE_W-1:0] data;
    } req_t;

    typedef struct {
        int                kind;
        logic [LINE_W-1:0] data;
    } rsp_t;

    logic              clk;
    logic              reset;
    logic              ic_command_valid;
    logic [AW-1:0]     ic_command_addr;
    logic              ic_bus_valid;
    logic              ic_invalidate;
    logic [AW-1:0]     ic_invalidate_addr;
    logic              dc_command_valid;
    logic              dc_command_store;
    logic [AW-1:0]     dc_command_addr;
    logic [LINE_W-1:0] dc_data_to_bus;
    logic              dc_bus_valid;
    logic              dc_bus_ready;
    logic [LINE_W-1:0] bus_data;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_store;
    logic [AW-1:0]     mem_req_addr;
    logic [LINE_W-1:0] mem_req_data;
    logic              mem_resp_valid;
    logic              mem_resp_ready;
    logic [LINE_W-1:0] mem_resp_data;

    int n_cmp;
    int n_fail;

    req_t exp_req_q[$];
    rsp_t exp_rsp_q[$];

    int            mem_ready_delay;
    int            ready_cnt;
    logic          mem_resp_hold;
    logic [AW-1:0] mem_last_addr;

    cache_bus_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .OFFSET_LENGTH (OL)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .ic_command_valid   (ic_command_valid),
        .ic_command_addr    (ic_command_addr),
        .ic_bus_valid       (ic_bus_valid),
        .ic_invalidate      (ic_invalidate),
        .ic_invalidate_addr (ic_invalidate_addr),
        .dc_command_valid   (dc_command_valid),
        .dc_command_store   (dc_command_store),
        .dc_command_addr    (dc_command_addr),
        .dc_data_to_bus     (dc_data_to_bus),
        .dc_bus_valid       (dc_bus_valid),
        .dc_bus_ready       (dc_bus_ready),
        .bus_data           (bus_data),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_store      (mem_req_store),
        .mem_req_addr       (mem_req_addr),
        .mem_req_data       (mem_req_data),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_ready     (mem_resp_ready),
        .mem_resp_data      (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LINE_W-1:0] line_for(input logic [AW-1:0] a);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_W / 32; i++) begin
            l[i*32 +: 32] = a[31:0] ^ 32'(32'h9E3779B9 * i) ^ 32'h5A5A0000;
        end
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_W / 32; i++) begin
            l[i*32 +: 32] = $urandom;
        end
        return l;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic push_req(input logic st, input logic [AW-1:0] a, input logic [LINE_W-1:0] d);
        req_t r;
        r.store = st;
        r.addr  = a;
        r.data  = d;
        exp_req_q.push_back(r);
    endtask

    task automatic push_rsp(input int k, input logic [LINE_W-1:0] d);
        rsp_t r;
        r.kind = k;
        r.data = d;
        exp_rsp_q.push_back(r);
    endtask

    // Memory model and scoreboard: checks happen before this cycle's drive.
    always @(negedge clk) begin
        if (ic_bus_valid || dc_bus_valid || dc_bus_ready) begin
            int   k;
            rsp_t e;
            n_cmp++;
            k = ic_bus_valid ? K_IC_FILL : (dc_bus_valid ? K_DC_FILL : K_DC_WB);
            if ((32'(ic_bus_valid) + 32'(dc_bus_valid) + 32'(dc_bus_ready)) != 1) begin
                n_fail++;
                $display("FAIL sb_pulse_onehot got ic=%0b dcv=%0b dcr=%0b want exactly one",
                         ic_bus_valid, dc_bus_valid, dc_bus_ready);
            end else if (exp_rsp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_pulse got kind %0d want no pulse", k);
            end else begin
                e = exp_rsp_q.pop_front();
                if (k != e.kind) begin
                    n_fail++;
                    $display("FAIL sb_rsp_kind got %0d want %0d", k, e.kind);
                end else if (k != K_DC_WB && bus_data !== e.data) begin
                    n_fail++;
                    $display("FAIL sb_bus_data got %h want %h (low 128b)", bus_data[127:0], e.data[127:0]);
                end
            end
        end

        if (mem_req_valid) begin
            mem_req_ready = (ready_cnt >= mem_ready_delay);
            if (mem_req_ready) begin
                req_t e;
                ready_cnt     = 0;
                mem_last_addr = mem_req_addr;
                n_cmp++;
                if (exp_req_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_req got addr %h want no request", mem_req_addr);
                end else begin
                    e = exp_req_q.pop_front();
                    if (mem_req_addr !== e.addr || mem_req_store !== e.store ||
                        (e.store && mem_req_data !== e.data)) begin
                        n_fail++;
                        $display("FAIL sb_mem_req got addr %h st %0b data %h want addr %h st %0b data %h",
                                 mem_req_addr, mem_req_store, mem_req_data[63:0],
                                 e.addr, e.store, e.data[63:0]);
                    end
                end
            end else begin
                ready_cnt++;
            end
        end else begin
            mem_req_ready = 1'b0;
            ready_cnt     = 0;
        end
        mem_resp_valid = mem_resp_ready && !mem_resp_hold;
        mem_resp_data  = line_for(mem_last_addr);
    end

    task automatic test_reset();
        cyc();
        ic_command_valid = 1'b1;
        ic_command_addr  = 64'h0000_0000_0000_0800;
        cyc();
        cyc();
        n_cmp++;
        if ({ic_bus_valid, dc_bus_valid, dc_bus_ready, mem_req_valid, mem_req_store,
             ic_invalidate, mem_resp_ready} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 0", {ic_bus_valid, dc_bus_valid, dc_bus_ready,
                     mem_req_valid, mem_req_store, ic_invalidate, mem_resp_ready});
        end
        n_cmp++;
        if (mem_req_addr !== '0 || ic_invalidate_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_addr got %h/%h want 0", mem_req_addr, ic_invalidate_addr);
        end
        n_cmp++;
        if (bus_data !== '0 || mem_req_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data got %h/%h want 0", bus_data[63:0], mem_req_data[63:0]);
        end
        ic_command_valid = 1'b0;
    endtask

    task automatic test_round_robin();
        int served;
        int ic_k;
        int dc_k;
        int expect_kind;
        reset = 1'b0;
        cyc();
        cyc();
        for (int k = 0; k < 4; k++) begin
            push_req(1'b0, 64'h2000 + 64'(k * 'h100), '0);
            push_rsp(K_DC_FILL, line_for(64'h2000 + 64'(k * 'h100)));
            push_req(1'b0, 64'h1000 + 64'(k * 'h100), '0);
            push_rsp(K_IC_FILL, line_for(64'h1000 + 64'(k * 'h100)));
        end
        served = 0;
        ic_k   = 0;
        dc_k   = 0;
        reset            = 1'b1;
        ic_command_valid = 1'b1;
        ic_command_addr  = 64'h1000;
        dc_command_valid = 1'b1;
        dc_command_store = 1'b0;
        dc_command_addr  = 64'h2000;
        for (int c = 0; c < 200 && served < 8; c++) begin
            cyc();
            if (ic_bus_valid || dc_bus_valid) begin
                expect_kind = (served % 2 == 0) ? K_DC_FILL : K_IC_FILL;
                n_cmp++;
                if ((dc_bus_valid ? K_DC_FILL : K_IC_FILL) != expect_kind) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d] got kind %0d want %0d", served,
                             dc_bus_valid ? K_DC_FILL : K_IC_FILL, expect_kind);
                end
                served++;
            end
            if (dc_bus_valid) begin
                dc_k++;
                if (dc_k < 4) dc_command_addr = 64'h2000 + 64'(dc_k * 'h100);
                else          dc_command_valid = 1'b0;
            end
            if (ic_bus_valid) begin
                ic_k++;
                if (ic_k < 4) ic_command_addr = 64'h1000 + 64'(ic_k * 'h100);
                else          ic_command_valid = 1'b0;
            end
        end
        ic_command_valid = 1'b0;
        dc_command_valid = 1'b0;
        n_cmp++;
        if (served != 8) begin
            n_fail++;
            $display("FAIL rr_served got %0d want 8", served);
        end
    endtask

    task automatic test_ic_read();
        logic [LINE_W-1:0] a_line;
        a_line = line_for(64'h1230);
        push_req(1'b0, 64'h1230, '0);
        push_rsp(K_IC_FILL, a_line);
        cyc();
        ic_command_valid = 1'b1;
        ic_command_addr  = 64'h1234;
        cyc();
        ic_command_valid = 1'b0;
        n_cmp++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h1230 || mem_req_store !== 1'b0) begin
            n_fail++;
            $display("FAIL ic_read_c1 got v=%0b addr=%h st=%0b want v=1 addr=1230 st=0",
                     mem_req_valid, mem_req_addr, mem_req_store);
        end
        cyc();
        n_cmp++;
        if (ic_bus_valid !== 1'b0 || mem_resp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ic_read_c2 got icv=%0b rrdy=%0b want icv=0 rrdy=1", ic_bus_valid, mem_resp_ready);
        end
        cyc();
        n_cmp++;
        if (ic_bus_valid !== 1'b1 || bus_data !== a_line) begin
            n_fail++;
            $display("FAIL ic_read_c3 got icv=%0b data=%h want icv=1 data=%h",
                     ic_bus_valid, bus_data[63:0], a_line[63:0]);
        end
        cyc();
        n_cmp++;
        if (ic_bus_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ic_read_c4 got icv=%0b want 0", ic_bus_valid);
        end
    endtask

    task automatic test_store_stall();
        logic [LINE_W-1:0] d;
        logic              stable_ok;
        logic              inv_ok;
        int                n_valid;
        int                n_rdy;
        int                n_inv;
        d = rand_line();
        mem_ready_delay = 5;
        push_req(1'b1, 64'h4000, d);
        push_rsp(K_DC_WB, '0);
        cyc();
        dc_command_valid = 1'b1;
        dc_command_store = 1'b1;
        dc_command_addr  = 64'h4000;
        dc_data_to_bus   = d;
        stable_ok = 1'b1;
        inv_ok    = 1'b1;
        n_valid   = 0;
        n_rdy     = 0;
        n_inv     = 0;
        for (int c = 0; c < 30; c++) begin
            cyc();
            if (mem_req_valid) begin
                n_valid++;
                if (mem_req_addr !== 64'h4000 || mem_req_store !== 1'b1 || mem_req_data !== d) stable_ok = 1'b0;
            end
            if (dc_bus_ready) n_rdy++;
            if (ic_invalidate) begin
                n_inv++;
                if (!dc_bus_ready || ic_invalidate_addr !== 64'h4000) inv_ok = 1'b0;
            end
            if (c == 0) begin
                dc_command_valid = 1'b0;
                dc_command_store = 1'b0;
                dc_data_to_bus   = '0;
            end
        end
        mem_ready_delay = 0;
        n_cmp++;
        if (!stable_ok || n_valid != 6) begin
            n_fail++;
            $display("FAIL store_stall_req got stable=%0b valid_cycles=%0d want stable=1 valid_cycles=6",
                     stable_ok, n_valid);
        end
        n_cmp++;
        if (n_rdy != 1) begin
            n_fail++;
            $display("FAIL store_stall_ready got %0d pulses want 1", n_rdy);
        end
`ifdef ARB_ICACHE_SNOOP_EN
        n_cmp++;
        if (n_inv != 1 || !inv_ok) begin
            n_fail++;
            $display("FAIL snoop_inval got %0d pulses ok=%0b want 1 pulse at 4000 with dc_bus_ready", n_inv, inv_ok);
        end
`else
        n_cmp++;
        if (n_inv != 0 || ic_invalidate_addr !== '0) begin
            n_fail++;
            $display("FAIL snoop_off got %0d pulses addr %h want 0", n_inv, ic_invalidate_addr);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [LINE_W-1:0] e;
        int                n_pulse;
        e = rand_line();
        push_req(1'b0, 64'h7000, '0);
        push_rsp(K_DC_FILL, line_for(64'h7000));
        push_req(1'b1, 64'h7100, e);
        push_rsp(K_DC_WB, '0);
        cyc();
        dc_command_valid = 1'b1;
        dc_command_store = 1'b0;
        dc_command_addr  = 64'h7000;
        n_pulse = 0;
        for (int c = 0; c < 40 && n_pulse < 2; c++) begin
            cyc();
            if (dc_bus_valid) begin
                n_pulse++;
                dc_command_store = 1'b1;
                dc_command_addr  = 64'h7100;
                dc_data_to_bus   = e;
            end else if (dc_bus_ready) begin
                n_pulse++;
                dc_command_valid = 1'b0;
                dc_command_store = 1'b0;
            end
        end
        n_cmp++;
        if (n_pulse != 2) begin
            n_fail++;
            $display("FAIL back_to_back got %0d pulses want 2", n_pulse);
        end
    endtask

    task automatic test_reset_mid();
        logic hit_wait;
        logic got;
        mem_resp_hold = 1'b1;
        push_req(1'b0, 64'h5000, '0);
        cyc();
        dc_command_valid = 1'b1;
        dc_command_store = 1'b0;
        dc_command_addr  = 64'h5000;
        hit_wait = 1'b0;
        for (int c = 0; c < 20 && !hit_wait; c++) begin
            cyc();
            dc_command_valid = 1'b0;
            if (mem_resp_ready) hit_wait = 1'b1;
        end
        n_cmp++;
        if (!hit_wait) begin
            n_fail++;
            $display("FAIL reset_mid_wait got no WAIT_RESP want mem_resp_ready=1");
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({ic_bus_valid, dc_bus_valid, dc_bus_ready, mem_req_valid, mem_resp_ready, ic_invalidate} !== 6'b0
            || bus_data !== '0 || mem_req_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs got ctrl=%b data=%h addr=%h want 0",
                     {ic_bus_valid, dc_bus_valid, dc_bus_ready, mem_req_valid, mem_resp_ready, ic_invalidate},
                     bus_data[63:0], mem_req_addr);
        end
        mem_resp_hold = 1'b0;
        cyc();
        cyc();
        n_cmp++;
        if ({ic_bus_valid, dc_bus_valid, dc_bus_ready} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_mid_nopulse got %b want 000", {ic_bus_valid, dc_bus_valid, dc_bus_ready});
        end
        push_req(1'b0, 64'h6000, '0);
        push_rsp(K_IC_FILL, line_for(64'h6000));
        reset            = 1'b1;
        ic_command_valid = 1'b1;
        ic_command_addr  = 64'h6008;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            cyc();
            ic_command_valid = 1'b0;
            if (ic_bus_valid) got = 1'b1;
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL reset_mid_recover got no ic_bus_valid want pulse");
        end
    endtask

    initial begin
        n_cmp            = 0;
        n_fail           = 0;
        reset            = 1'b0;
        ic_command_valid = 1'b0;
        ic_command_addr  = '0;
        dc_command_valid = 1'b0;
        dc_command_store = 1'b0;
        dc_command_addr  = '0;
        dc_data_to_bus   = '0;
        mem_req_ready    = 1'b0;
        mem_resp_valid   = 1'b0;
        mem_resp_data    = '0;
        mem_ready_delay  = 0;
        ready_cnt        = 0;
        mem_resp_hold    = 1'b0;
        mem_last_addr    = '0;

        test_reset();
        test_round_robin();
        cyc();
        test_ic_read();
        cyc();
        test_store_stall();
        cyc();
        test_back_to_back();
        cyc();
        test_reset_mid();
        cyc();
        cyc();

        n_cmp++;
        if (exp_req_q.size() != 0 || exp_rsp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got req=%0d rsp=%0d left want 0/0", exp_req_q.size(), exp_rsp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
